// File: rtl/branch_pkg.sv
// Shared branch op encoding and PC-redirect codes for the decoder, branch_ctrl and PC block.
package branch_pkg;

   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_JMP  = 3'd1,
      OP_BT   = 3'd2,
      OP_BF   = 3'd3,
      OP_CALL = 3'd4,
      OP_RET  = 3'd5
   } br_op_t;

   localparam logic [1:0] BR_SEQ = 2'b00;
   localparam logic [1:0] BR_IFT = 2'b01;
   localparam logic [1:0] BR_IFF = 2'b10;
   localparam logic [1:0] BR_ALW = 2'b11;

endpackage

// File: rtl/branch_ctrl_if.sv
// Decoder/PC-side signal bundle of branch_ctrl; slave is the branch_ctrl view.
interface branch_ctrl_if #(
   parameter int D      = 12,
   parameter int LUT_AW = 4
);
   import branch_pkg::*;

   logic [D-1:0]      prog_ctr;
   br_op_t            op;
   logic [LUT_AW-1:0] lut_idx;
   logic              flag_we;
   logic              flag_in;
   logic              lut_we;
   logic [LUT_AW-1:0] lut_waddr;
   logic [D-1:0]      lut_wdata;
   logic [1:0]        branch;
   logic              jcnd;
   logic [D-1:0]      target;
   logic              ras_empty;
   logic              ras_full;
   logic              ras_err;

   modport slave (
      input  prog_ctr, op, lut_idx, flag_we, flag_in, lut_we, lut_waddr, lut_wdata,
      output branch, jcnd, target, ras_empty, ras_full, ras_err
   );

   modport master (
      output prog_ctr, op, lut_idx, flag_we, flag_in, lut_we, lut_waddr, lut_wdata,
      input  branch, jcnd, target, ras_empty, ras_full, ras_err
   );

endinterface

// File: rtl/branch_ctrl_ras.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module ras #(
   parameter int D         = 12,
   parameter int RAS_DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [D-1:0] push_data,
   output logic [D-1:0] top,
   output logic         empty,
   output logic         full,
   output logic         ovf,
   output logic         unf
);
   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE = 1;
   localparam logic [CW-1:0] CNT_ONE = 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

   logic [D-1:0]  mem [RAS_DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [CW-1:0] count;

   always_comb begin
      rptr  = wptr - PTR_ONE;
      top   = mem[rptr];
      empty = (count == '0);
      full  = (count == CNT_MAX);
      ovf   = push && full;
      unf   = pop && !push && empty;
   end

   // Overflow just advances the write pointer; count stays saturated so the newest entries survive.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
         wptr  <= '0;
         count <= '0;
      end else if (push) begin
         mem[wptr] <= push_data;
         wptr      <= wptr + PTR_ONE;
         if (!full) count <= count + CNT_ONE;
      end else if (pop && !empty) begin
         wptr  <= rptr;
         count <= count - CNT_ONE;
      end
   end

endmodule

// File: rtl/branch_ctrl.sv
// PC redirect source: condition flag, writable jump-target LUT and return-address stack.
module branch_ctrl
   import branch_pkg::*;
#(
   parameter int D         = 12,
   parameter int LUT_AW    = 4,
   parameter int RAS_DEPTH = 4
) (
   input logic          clk,
   input logic          reset,
   branch_ctrl_if.slave bus
);
   localparam int LUT_N = 2 ** LUT_AW;

   logic [D-1:0] lut [LUT_N];
   logic         flag;
   logic         err;
   logic         push;
   logic         pop;
   logic [D-1:0] ras_top;
   logic         empty;
   logic         full;
   logic         ovf;
   logic         unf;
   logic [1:0]   br;
   logic [D-1:0] tgt;

   ras #(
      .D         (D),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (bus.prog_ctr + D'(1)),
      .top       (ras_top),
      .empty     (empty),
      .full      (full),
      .ovf       (ovf),
      .unf       (unf)
   );

   always_comb begin
      push = 1'b0;
      pop  = 1'b0;
      br   = BR_SEQ;
      tgt  = lut[bus.lut_idx];
      case (bus.op)
         OP_JMP:  br = BR_ALW;
         OP_BT:   br = BR_IFT;
         OP_BF:   br = BR_IFF;
         OP_CALL: begin
            br   = BR_ALW;
            push = 1'b1;
         end
         OP_RET: begin
            pop = 1'b1;
            if (!empty) begin
               br  = BR_ALW;
               tgt = ras_top;
            end else begin
               tgt = '0;
            end
         end
         default: ;
      endcase
      // Force a benign redirect while reset is held, independent of op.
      if (!reset) begin
         br  = BR_SEQ;
         tgt = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flag <= 1'b0;
         err  <= 1'b0;
         for (int unsigned i = 0; i < LUT_N; i++) lut[i] <= '0;
      end else begin
         if (bus.flag_we) flag <= bus.flag_in;
         if (ovf || unf) err <= 1'b1;
         if (bus.lut_we) lut[bus.lut_waddr] <= bus.lut_wdata;
      end
   end

   assign bus.branch    = br;
   assign bus.jcnd      = flag;
   assign bus.target    = tgt;
   assign bus.ras_empty = empty;
   assign bus.ras_full  = full;
   assign bus.ras_err   = err;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed vector bench for branch_ctrl: table of per-cycle stimulus/expectations plus corner sequences.
module tb_branch_ctrl;
   import branch_pkg::*;

   localparam int D = 12;
   localparam int LUT_AW = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   tests = 0;
   int   fails = 0;

   branch_ctrl_if #(.D(D), .LUT_AW(LUT_AW)) bus ();

   branch_ctrl #(.D(D), .LUT_AW(LUT_AW), .RAS_DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [3:0]  idx;
      logic        fwe;
      logic        fin;
      logic        lwe;
      logic [3:0]  waddr;
      logic [11:0] wdata;
      logic [11:0] pc;
      logic [1:0]  br;
      logic        jc;
      logic [11:0] tgt;
      logic        emp;
      logic        full;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [2:0] op, logic [3:0] idx, logic fwe, logic fin,
                               logic lwe, logic [3:0] waddr, logic [11:0] wdata, logic [11:0] pc,
                               logic [1:0] br, logic jc, logic [11:0] tgt,
                               logic emp, logic full, logic err);
      vec_t v;
      v.op = op; v.idx = idx; v.fwe = fwe; v.fin = fin; v.lwe = lwe; v.waddr = waddr;
      v.wdata = wdata; v.pc = pc; v.br = br; v.jc = jc; v.tgt = tgt;
      v.emp = emp; v.full = full; v.err = err;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [3:0] idx, input logic fwe,
                        input logic fin, input logic lwe, input logic [3:0] waddr,
                        input logic [11:0] wdata, input logic [11:0] pc);
      bus.op = br_op_t'(op);
      bus.lut_idx = idx;
      bus.flag_we = fwe;
      bus.flag_in = fin;
      bus.lut_we = lwe;
      bus.lut_waddr = waddr;
      bus.lut_wdata = wdata;
      bus.prog_ctr = pc;
   endtask

   task automatic chk_out(input string nm, input logic [1:0] br, input logic jc,
                          input logic [11:0] tgt, input logic emp, input logic full,
                          input logic err);
      chk({nm, ".branch"}, 16'(bus.branch), 16'(br));
      chk({nm, ".jcnd"}, 16'(bus.jcnd), 16'(jc));
      chk({nm, ".target"}, 16'(bus.target), 16'(tgt));
      chk({nm, ".ras_empty"}, 16'(bus.ras_empty), 16'(emp));
      chk({nm, ".ras_full"}, 16'(bus.ras_full), 16'(full));
      chk({nm, ".ras_err"}, 16'(bus.ras_err), 16'(err));
   endtask

   initial begin
      //            op idx fwe fin lwe wa  wdata   pc      br jc tgt     emp full err
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h000, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 3, 12'h0A5, 12'h000, 0, 0, 12'h000, 1, 0, 0));
      vecs.push_back(mk(1, 3, 0, 0, 0, 0, 12'h000, 12'h000, 3, 0, 12'h0A5, 1, 0, 0));
      vecs.push_back(mk(1, 3, 0, 0, 1, 3, 12'h111, 12'h000, 3, 0, 12'h0A5, 1, 0, 0));
      vecs.push_back(mk(1, 3, 0, 0, 0, 0, 12'h000, 12'h000, 3, 0, 12'h111, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, 12'h000, 12'h000, 0, 0, 12'h000, 1, 0, 0));
      vecs.push_back(mk(2, 3, 0, 0, 0, 0, 12'h000, 12'h000, 1, 1, 12'h111, 1, 0, 0));
      vecs.push_back(mk(3, 3, 1, 0, 0, 0, 12'h000, 12'h000, 2, 1, 12'h111, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h000, 1, 0, 0));
      vecs.push_back(mk(6, 3, 0, 0, 1, 1, 12'h200, 12'h000, 0, 0, 12'h111, 1, 0, 0));
      vecs.push_back(mk(4, 1, 0, 0, 0, 0, 12'h000, 12'h010, 3, 0, 12'h200, 1, 0, 0));
      vecs.push_back(mk(4, 1, 0, 0, 0, 0, 12'h000, 12'h020, 3, 0, 12'h200, 0, 0, 0));
      vecs.push_back(mk(5, 1, 0, 0, 0, 0, 12'h000, 12'h000, 3, 0, 12'h021, 0, 0, 0));
      vecs.push_back(mk(5, 1, 0, 0, 0, 0, 12'h000, 12'h000, 3, 0, 12'h011, 0, 0, 0));
      vecs.push_back(mk(7, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h000, 1, 0, 0));
      vecs.push_back(mk(4, 1, 0, 0, 0, 0, 12'h000, 12'h001, 3, 0, 12'h200, 1, 0, 0));
      vecs.push_back(mk(4, 1, 0, 0, 0, 0, 12'h000, 12'h002, 3, 0, 12'h200, 0, 0, 0));
      vecs.push_back(mk(4, 1, 0, 0, 0, 0, 12'h000, 12'h003, 3, 0, 12'h200, 0, 0, 0));
      vecs.push_back(mk(4, 1, 0, 0, 0, 0, 12'h000, 12'h004, 3, 0, 12'h200, 0, 0, 0));
      vecs.push_back(mk(4, 1, 0, 0, 0, 0, 12'h000, 12'h005, 3, 0, 12'h200, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h000, 0, 1, 1));
      vecs.push_back(mk(5, 0, 0, 0, 0, 0, 12'h000, 12'h000, 3, 0, 12'h006, 0, 1, 1));
      vecs.push_back(mk(5, 0, 0, 0, 0, 0, 12'h000, 12'h000, 3, 0, 12'h005, 0, 0, 1));
      vecs.push_back(mk(5, 0, 0, 0, 0, 0, 12'h000, 12'h000, 3, 0, 12'h004, 0, 0, 1));
      vecs.push_back(mk(5, 0, 0, 0, 0, 0, 12'h000, 12'h000, 3, 0, 12'h003, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h000, 1, 0, 1));

      // Reset held: a JMP on the bus must still present a sequential redirect.
      drive(3'd1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000, 12'h000);
      #3;
      chk_out("in_reset", 2'b00, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].op, vecs[i].idx, vecs[i].fwe, vecs[i].fin, vecs[i].lwe,
               vecs[i].waddr, vecs[i].wdata, vecs[i].pc);
         #1;
         chk_out($sformatf("vec%0d", i), vecs[i].br, vecs[i].jc, vecs[i].tgt,
                 vecs[i].emp, vecs[i].full, vecs[i].err);
      end

      // Asynchronous reset between edges wipes flag, LUT and sticky error at once.
      @(negedge clk);
      drive(3'd1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd0, 12'h000, 12'h000);
      @(posedge clk);
      #2;
      chk_out("pre_async", 2'b11, 1'b1, 12'h111, 1'b1, 1'b0, 1'b1);
      reset = 1'b0;
      #1;
      chk_out("async_rst", 2'b00, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      drive(3'd1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000, 12'h000);
      #1;
      chk_out("post_rst", 2'b11, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);

      // Underflow: RET on empty stack, then stickiness through valid ops.
      @(negedge clk);
      drive(3'd5, 4'd3, 1'b0, 1'b0, 1'b1, 4'd2, 12'h3C3, 12'h000);
      #1;
      chk_out("ret_empty", 2'b00, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      drive(3'd1, 4'd2, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000, 12'h000);
      #1;
      chk_out("err_sticky1", 2'b11, 1'b0, 12'h3C3, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      drive(3'd4, 4'd2, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000, 12'hFFF);
      #1;
      chk_out("call_fff", 2'b11, 1'b0, 12'h3C3, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      drive(3'd5, 4'd2, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000, 12'h000);
      #1;
      chk_out("ret_wrap", 2'b11, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      drive(3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000, 12'h000);
      #1;
      chk_out("err_sticky2", 2'b00, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Source side of the program-counter redirect interface: produces branch[1:0], jcnd and target, which the PC block samples at the next rising clk.
- Sits between the instruction decoder and the PC block.
- Holds the condition flag register, a writable jump-target lookup table (LUT) and a small return-address stack (RAS) for call/return.
- All state is sequential; redirect outputs are combinational from the current op and registered state.

Parameters:
- D, 12, PC/target width; must match the PC block.
- LUT_AW, 4, LUT address width (2**LUT_AW entries of D bits).
- RAS_DEPTH, 4, return-address stack entries (power of 2, >=2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- prog_ctr  in  D  current PC value from the PC block.
- op  in  3  branch op from the decoder (branch_pkg::br_op_t).
- lut_idx  in  LUT_AW  LUT entry selected as jump target.
- flag_we  in  1  write enable for the condition flag.
- flag_in  in  1  new condition flag value.
- lut_we  in  1  LUT write enable.
- lut_waddr  in  LUT_AW  LUT write address.
- lut_wdata  in  D  LUT write data.
- branch  out  2  redirect code to the PC block.
- jcnd  out  1  condition to the PC block.
- target  out  D  redirect address to the PC block.
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_err  out  1  sticky overflow/underflow error.

Behaviour:
- Branch codes:
  - 00 = PC+1
  - 01 = take if jcnd
  - 10 = take if !jcnd
  - 11 = unconditional
- Ops: NONE=0, JMP=1, BT=2, BF=3, CALL=4, RET=5; codes 6-7 are treated as NONE.
- Reset (reset==0, asynchronous):
  - flag, all LUT entries, RAS contents, stack pointer and ras_err all clear to 0.
  - Outputs while in reset: branch=00, jcnd=0, target=0, ras_empty=1, ras_full=0, ras_err=0.
- jcnd always equals the registered flag. flag_we updates the flag at the clk edge.
  - A flag write and a BT/BF in the same cycle: BT/BF uses the old flag (no bypass).
- Per-op outputs (combinational, zero latency; PC redirects on the next edge):
  - NONE: branch=00, target=LUT[lut_idx].
  - JMP: branch=11, target=LUT[lut_idx].
  - BT: branch=01, target=LUT[lut_idx].
  - BF: branch=10, target=LUT[lut_idx].
  - CALL: branch=11, target=LUT[lut_idx]. Pushes prog_ctr+1 (mod 2**D) at the edge.
  - RET, RAS not empty: branch=11, target=top of RAS. Pops at the edge.
  - RET, RAS empty: branch=00, target=0, no pop, ras_err<=1.
- RAS overflow: CALL while full overwrites the oldest entry (circular).
  - Depth stays RAS_DEPTH, ras_err<=1, and the newest RAS_DEPTH addresses are retained.
- ras_err is sticky until reset.
- LUT write:
  - lut_we writes lut_wdata at the edge.
  - A same-cycle read of the same index returns the old value.
  - lut_we is independent of op.
- prog_ctr = 2**D-1 with CALL pushes 0 (wrap).
- Reset asserted mid-operation: pending pushes and writes are discarded; state is cleared immediately.

Decomposition:
- branch_pkg holds:
  - br_op_t enum.
  - Branch code constants BR_SEQ=2'b00, BR_IFT=2'b01, BR_IFF=2'b10, BR_ALW=2'b11.
- Sub-module ras (parameters D, RAS_DEPTH):
  - Inputs: push, pop, push_data.
  - Outputs: top, empty, full, ovf, unf.
  - Uses a circular pointer plus a count.
- branch_ctrl keeps the flag register, the LUT, op decode and ras_err.

Test Plan:
- Reset, then op=NONE -> branch=00, jcnd=0, target=0, ras_empty=1, ras_err=0. Async assertion mid-cycle clears outputs before the next edge.
- Write LUT[3]=12'h0A5, then op=JMP with lut_idx=3 -> branch=11, target=0x0A5. Same-cycle write of LUT[3]=0x111 with read -> target still 0x0A5, next cycle 0x111.
- flag_we=1, flag_in=1, then op=BT -> branch=01, jcnd=1. Op=BF with flag_we=1, flag_in=0 in the same cycle -> jcnd=1 that cycle, 0 the next.
- CALL at prog_ctr=0x010, then 0x020, then RET, RET -> targets 0x021, then 0x011. ras_empty=1 afterwards, ras_err=0.
- Five CALLs at prog_ctr=1..5 (RAS_DEPTH=4) -> ras_full=1 and ras_err=1 after the 5th. Four RETs -> targets 6, 5, 4, 3.
- RET on empty RAS -> branch=00, target=0, ras_err=1 and stays 1 through later valid ops until reset. CALL at prog_ctr=0xFFF pushes 0x000.
